// File: rtl/cla_sub_seq.sv
// cla_sub_seq: multi-cycle lookahead subtractor.
// Computes diff = a - b as a + ~b + 1, resolving SLICE bits per clock with a
// SLICE-bit lookahead group; the group carry is registered between cycles.
// Flags borrow/ovf/zero become valid with the one-cycle done pulse and hold
// until the next accepted start.
// Optional feature macro: CLA_SUB_CMP_EN adds the lt_u / lt_s compare outputs.
module cla_sub_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
`ifdef CLA_SUB_CMP_EN
    ,
    output logic             lt_u,
    output logic             lt_s
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic [CNT_W-1:0]   idx;

    logic [SLICE-1:0]   op_a;
    logic [SLICE-1:0]   op_b;
    logic [SLICE-1:0]   gen;
    logic [SLICE-1:0]   prop;
    logic [SLICE:0]     c;
    logic               prod;
    logic [SLICE-1:0]   sum_s;
    logic               cout_s;
    logic [WIDTH-1:0]   diff_nxt;
    logic               accept;
    logic               ovf_nxt;

    assign accept = start && (state != RUN);

    // Lookahead group for the current slice: every carry is a flat
    // sum-of-products over generate/propagate terms and the incoming carry.
    always_comb begin
        // NOTE: every variable gets a default before any conditional or loop
        // writes it, so no latch is inferred.
        op_a     = a_q[idx*SLICE +: SLICE];
        op_b     = ~b_q[idx*SLICE +: SLICE];
        gen      = op_a & op_b;
        prop     = op_a ^ op_b;
        c        = '0;
        prod     = 1'b0;
        c[0]     = carry;
        for (int i = 0; i < SLICE; i++) begin
            for (int j = 0; j <= i + 1; j++) begin
                // j == 0 is the chain from the incoming carry, j > 0 starts at gen[j-1]
                prod = (j == 0) ? carry : gen[j-1];
                for (int k = j; k <= i; k++) begin
                    prod = prod & prop[k];
                end
                c[i+1] = c[i+1] | prod;
            end
        end
        sum_s    = prop ^ c[SLICE-1:0];
        cout_s   = c[SLICE];
        diff_nxt = diff;
        diff_nxt[idx*SLICE +: SLICE] = sum_s;
        ovf_nxt  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Control FSM and datapath registers; outputs are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand registers are reset along with the rest; they
            // are few enough that a deterministic post-reset value costs nothing.
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
`ifdef CLA_SUB_CMP_EN
            lt_u   <= 1'b0;
            lt_s   <= 1'b0;
`endif
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            state <= RUN;
            a_q   <= a;
            b_q   <= b;
            carry <= 1'b1;
            idx   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    diff  <= diff_nxt;
                    carry <= cout_s;
                    idx   <= idx + CNT_W'(1);
                    if (idx == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        borrow <= ~cout_s;
                        ovf    <= ovf_nxt;
                        zero   <= ~|diff_nxt;
`ifdef CLA_SUB_CMP_EN
                        lt_u   <= ~cout_s;
                        lt_s   <= diff_nxt[WIDTH-1] ^ ovf_nxt;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_seq.sv
// Self-checking bench for cla_sub_seq: directed cases plus randomized
// operations against an arithmetic reference model.
module tb_cla_sub_seq;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int N      = WIDTH / SLICE;
    localparam int BUDGET = 4 * N + 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;
`ifdef CLA_SUB_CMP_EN
    logic             lt_u;
    logic             lt_s;
`endif

    int checks = 0;
    int errors = 0;

    cla_sub_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .zero   (zero)
`ifdef CLA_SUB_CMP_EN
        ,
        .lt_u   (lt_u),
        .lt_s   (lt_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
        logic             zero;
        logic             lt_u;
        logic             lt_s;
    } exp_t;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint r;
        sx       = longint'($signed(x));
        sy       = longint'($signed(y));
        r        = sx - sy;
        e.diff   = x - y;
        e.borrow = (x < y);
        e.ovf    = (r > longint'(2 ** (WIDTH - 1) - 1)) || (r < -longint'(2 ** (WIDTH - 1)));
        e.zero   = (x == y);
        e.lt_u   = (x < y);
        e.lt_s   = (sx < sy);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs free: present a request for one edge,
    // then return at the negedge after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
    endtask

    // Counts busy cycles until done; returns at the negedge where done is seen.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < BUDGET) begin
            if (busy !== 1'b1) check("busy_during_run", 32'(busy), 32'd1);
            lat++;
            @(negedge clk);
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic check_result(input exp_t e);
        check("diff", 32'(diff), 32'(e.diff));
        check("borrow", 32'(borrow), 32'(e.borrow));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("zero", 32'(zero), 32'(e.zero));
`ifdef CLA_SUB_CMP_EN
        check("lt_u", 32'(lt_u), 32'(e.lt_u));
        check("lt_s", 32'(lt_s), 32'(e.lt_s));
`endif
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int lat;
        launch(x, y);
        check("diff_cleared_at_start", 32'(diff), 32'd0);
        wait_done(0, lat);
        check("latency", 32'(lat), 32'(N));
        check_result(model(x, y));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'd0);
        check({tag, "_flags"}, 32'({borrow, ovf, zero}), 32'd0);
`ifdef CLA_SUB_CMP_EN
        check({tag, "_lt"}, 32'({lt_u, lt_s}), 32'd0);
`endif
    endtask

    initial begin
        exp_t             e;
        int               lat;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] held;
        bit               saw_done;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtraction, then the result holds and done is a single pulse.
        run_op(16'h0005, 16'h0003);
        held = diff;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        check("diff_holds", 32'(diff), 32'(held));
        check("zero_holds", 32'(zero), 32'd0);

        run_op(16'h0003, 16'h0005);
        @(negedge clk);
        run_op(16'h8000, 16'h0001);
        @(negedge clk);

        // Equal operands, then a back-to-back start in the done cycle.
        run_op(16'h1234, 16'h1234);
        launch(16'hFFFF, 16'h0001);
        wait_done(0, lat);
        check("b2b_latency", 32'(lat), 32'(N));
        check_result(model(16'hFFFF, 16'h0001));
        @(negedge clk);

        // A start while busy must be ignored.
        launch(16'h00F0, 16'h000F);
        check("busy_cycle1", 32'(busy), 32'd1);
        start = 1'b1;
        a     = 16'h0000;
        b     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat);
        check("ignored_start_latency", 32'(lat), 32'(N));
        check_result(model(16'h00F0, 16'h000F));
        @(negedge clk);

        // Reset mid-operation: outputs clear immediately and no done follows.
        launch(16'h0100, 16'h0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_done |= done;
        end
        rst_n = 1'b1;
        repeat (N + 2) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("no_done_after_abort", 32'(saw_done), 32'd0);
        check_all_zero("post_reset");
        run_op(16'h0001, 16'h0001);

        // Randomized operations, mixing idle gaps and back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: begin x[WIDTH-1] = 1'b1; y[WIDTH-1] = 1'b0; end
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("rand_done_drops", 32'(done), 32'd0);
            end
            e = model(x, y);
            launch(x, y);
            wait_done(0, lat);
            check("rand_latency", 32'(lat), 32'(N));
            check_result(e);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
